// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types, constants and helpers for the button interrupt controller
// Contents:
//   NUM_BTN         number of buttons served by the controller
//   DEF_VEC_BASE    default handler address of button 3
//   DEF_VEC_STRIDE  default spacing between handler addresses
//   state_t         request FSM state encoding
//   highest_set()   index of the highest set bit (bit 3 wins)
//   vec_addr()      handler address for a given button index
package int_ctrl_pkg;

  localparam int NUM_BTN = 4;

  localparam logic [15:0] DEF_VEC_BASE   = 16'h0f80;
  localparam logic [15:0] DEF_VEC_STRIDE = 16'h0020;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  // Later iterations overwrite earlier ones, so the highest set index wins.
  function automatic logic [1:0] highest_set(input logic [NUM_BTN-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Button 3 sits at the base; lower buttons step upwards by the stride.
  // The sum is truncated to 16 bits, so large strides simply wrap.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input logic [1:0]  src);
    logic [1:0] slot;
    slot = 2'd3 - src;
    return base + stride * {14'd0, slot};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debounce counter and rising-edge pulse for one button
// Parameters:
//   DB_CYCLES  consecutive stable synchronized samples needed to change the debounced level
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   btn_raw  asynchronous, bouncing button level
//   rise     one-cycle pulse on the cycle after the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter measures how long the synchronized level has disagreed with
  // the debounced level; any agreeing sample (a bounce back) restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_int_ctrl.sv
// rtl/button_int_ctrl.sv - debounced four-button vectored interrupt controller
// Parameters:
//   DB_CYCLES   debounce length in clk cycles
//   VEC_BASE    handler address of button 3
//   VEC_STRIDE  spacing between handler addresses
// Optional build macro:
//   INT_MASK_EN adds int_mask; masked buttons cannot set new pending bits
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   buttons_raw  asynchronous bouncing button levels, active-high
//   int_mask     (INT_MASK_EN only) per-button event mask, 1 = masked
//   int_ack      CPU took the interrupt branch
//   int_ret      CPU returned from the handler
//   int_req      interrupt request
//   int_vec      handler address, valid while int_req is high
//   int_src      index of the button requested or in service
//   in_service   handler running
//   pending      latched, unacknowledged button events
module button_int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          DB_CYCLES  = 16,
  parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] buttons_raw,
`ifdef INT_MASK_EN
  input  logic [NUM_BTN-1:0] int_mask,
`endif
  input  logic               int_ack,
  input  logic               int_ret,
  output logic               int_req,
  output logic [15:0]        int_vec,
  output logic [1:0]         int_src,
  output logic               in_service,
  output logic [NUM_BTN-1:0] pending
);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] set_bits;
  logic [NUM_BTN-1:0] clr_bits;
  state_t             state;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(buttons_raw[i]),
      .rise   (rise[i])
    );
  end

`ifdef INT_MASK_EN
  assign set_bits = rise & ~int_mask;
`else
  assign set_bits = rise;
`endif

  // The acknowledged source is cleared on the ack edge; a new event on the
  // same button in that cycle is OR-ed in afterwards and therefore wins.
  assign clr_bits = (state == ST_REQ && int_ack) ? NUM_BTN'(1) << int_src : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= '0;
      int_src    <= '0;
      int_vec    <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      pending <= (pending & ~clr_bits) | set_bits;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            int_src <= highest_set(pending);
            int_vec <= vec_addr(VEC_BASE, VEC_STRIDE, highest_set(pending));
            int_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        // int_src/int_vec are frozen here so a later, higher-priority event
        // only accumulates in pending until the next pass through IDLE.
        ST_REQ: begin
          if (int_ack) begin
            int_req    <= 1'b0;
            in_service <= 1'b1;
            state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (int_ret) begin
            in_service <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          int_req    <= 1'b0;
          in_service <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_int_ctrl.sv
// tb/tb_button_int_ctrl.sv - self-checking bench for button_int_ctrl with a window-based reference model
module tb_button_int_ctrl;

  localparam int          DB = 4;
  localparam logic [15:0] VB = 16'h0f80;
  localparam logic [15:0] VS = 16'h0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  buttons_raw = '0;
  logic [3:0]  int_mask = '0;
  logic        int_ack = 1'b0;
  logic        int_ret = 1'b0;
  logic        int_req;
  logic [15:0] int_vec;
  logic [1:0]  int_src;
  logic        in_service;
  logic [3:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  button_int_ctrl #(
    .DB_CYCLES (DB),
    .VEC_BASE  (VB),
    .VEC_STRIDE(VS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buttons_raw(buttons_raw),
`ifdef INT_MASK_EN
    .int_mask   (int_mask),
`endif
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_src    (int_src),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button's debounced level flips once the last DB synchronized samples
  // all show the opposite level; the event reaches pending one cycle later.
  logic [3:0]    m_s1, m_s2, m_db, m_rise, m_pend, m_flip, m_pend_n, m_clr;
  logic [DB-1:0] m_win [4];
  logic [DB-1:0] mw_next [4];
  int            m_state;   // 0 idle, 1 requesting, 2 in service
  logic [1:0]    m_src;
  logic [15:0]   m_vec;
  logic          m_req, m_svc;

  function automatic int top_idx(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) if (p[i]) return i;
    return 0;
  endfunction

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      mw_next[b] = {m_win[b][DB-2:0], m_s2[b]};
      m_flip[b]  = m_db[b] ? (mw_next[b] == '0) : (mw_next[b] == '1);
    end
    m_clr    = (m_state == 1 && int_ack) ? (4'b0001 << m_src) : 4'b0000;
    m_pend_n = (m_pend & ~m_clr) | (m_rise & ~int_mask);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_rise <= '0; m_pend <= '0;
      for (int b = 0; b < 4; b++) m_win[b] <= '0;
      m_state <= 0; m_src <= '0; m_vec <= '0; m_req <= 1'b0; m_svc <= 1'b0;
    end else begin
      m_s1   <= buttons_raw;
      m_s2   <= m_s1;
      for (int b = 0; b < 4; b++) m_win[b] <= mw_next[b];
      m_db   <= m_db ^ m_flip;
      m_rise <= m_flip & ~m_db;
      m_pend <= m_pend_n;
      case (m_state)
        0: if (m_pend != 0) begin
             m_src   <= 2'(top_idx(m_pend));
             m_vec   <= 16'(int'(VB) + (3 - top_idx(m_pend)) * int'(VS));
             m_req   <= 1'b1;
             m_state <= 1;
           end
        1: if (int_ack) begin m_req <= 1'b0; m_svc <= 1'b1; m_state <= 2; end
        2: if (int_ret) begin m_svc <= 1'b0; m_state <= 0; end
        default: m_state <= 0;
      endcase
    end
  end

  // Continuous comparison; vector/source only matter while requesting or serving.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model",
            {8'd0, int_req, in_service, pending, (m_req | m_svc) ? int_src : 2'b00,
             m_req ? int_vec : 16'h0000},
            {8'd0, m_req, m_svc, m_pend, (m_req | m_svc) ? m_src : 2'b00,
             m_req ? m_vec : 16'h0000});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; int_ack = 1'b0; int_ret = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name, input int maxc);
    int k;
    k = 0;
    while (!int_req && k < maxc) begin
      step();
      k++;
    end
    check(name, int_req, 1);
  endtask

  task automatic ack_ret();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    int_ret = 1'b1; step(); int_ret = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  press;
    logic [3:0]  exp_pend;
    logic [1:0]  exp_src;
    logic [15:0] exp_vec;
    bit          two;
    logic [1:0]  exp_src2;
    logic [15:0] exp_vec2;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int k;
    bit seen;
    logic [3:0] tgt;

    tbl[0] = '{4'b0100, 4'b0100, 2'd2, 16'h0fa0, 1'b0, 2'd0, 16'h0000};
    tbl[1] = '{4'b0001, 4'b0001, 2'd0, 16'h0fe0, 1'b0, 2'd0, 16'h0000};
    tbl[2] = '{4'b0010, 4'b0010, 2'd1, 16'h0fc0, 1'b0, 2'd0, 16'h0000};
    tbl[3] = '{4'b1000, 4'b1000, 2'd3, 16'h0f80, 1'b0, 2'd0, 16'h0000};
    tbl[4] = '{4'b1001, 4'b1001, 2'd3, 16'h0f80, 1'b1, 2'd0, 16'h0fe0};
    tbl[5] = '{4'b0110, 4'b0110, 2'd2, 16'h0fa0, 1'b1, 2'd1, 16'h0fc0};

    // Reset state, with all buttons held high during reset
    rst = 1'b1; buttons_raw = 4'hf;
    step(); step();
    chk_en = 1'b1;
    check("reset_outputs", {int_req, in_service, int_src, pending, int_vec}, 0);
    buttons_raw = 4'h0;
    step(); step();
    check("reset_outputs_held", {int_req, in_service, int_src, pending, int_vec}, 0);

    // Table of single and simultaneous presses
    for (int t = 0; t < 6; t++) begin
      do_reset();
      buttons_raw = tbl[t].press;
      k = 0;
      while (pending == 0 && k < 20) begin step(); k++; end
      check($sformatf("pend_latency_%0d", t), k <= DB + 4, 1);
      check($sformatf("pend_%0d", t), pending, tbl[t].exp_pend);
      wait_req($sformatf("req_%0d", t), 4);
      check($sformatf("src_%0d", t), int_src, tbl[t].exp_src);
      check($sformatf("vec_%0d", t), int_vec, tbl[t].exp_vec);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      check($sformatf("svc_%0d", t), {int_req, in_service}, 2'b01);
      check($sformatf("pend_clr_%0d", t), pending,
            tbl[t].exp_pend & ~(4'b0001 << tbl[t].exp_src));
      int_ret = 1'b1; step(); int_ret = 1'b0;
      if (tbl[t].two) begin
        step();
        check($sformatf("req2_%0d", t), int_req, 1);
        check($sformatf("vec2_%0d", t), int_vec, tbl[t].exp_vec2);
        check($sformatf("src2_%0d", t), int_src, tbl[t].exp_src2);
        ack_ret();
      end
      buttons_raw = 4'h0;
      repeat (10) step();
    end

    // Bouncing button 1 never qualifies
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      buttons_raw[1] = ((i / 2) % 2) != 0;
      step();
      if (pending != 0) seen = 1'b1;
    end
    buttons_raw = 4'h0;
    repeat (8) begin step(); if (pending != 0) seen = 1'b1; end
    check("bounce_no_pending", seen, 0);

    // Stray ack/ret in IDLE are ignored
    int_ack = 1'b1; int_ret = 1'b1; step(); int_ack = 1'b0; int_ret = 1'b0;
    check("stray_ack_ret", {int_req, in_service}, 2'b00);

    // Button 3 arrives while button 0 is in service: no nesting
    do_reset();
    buttons_raw = 4'b0001;
    wait_req("nest_req0", DB + 8);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    buttons_raw = 4'b1001;
    seen = 1'b0;
    repeat (12) begin step(); if (int_req) seen = 1'b1; end
    check("nest_no_req", seen, 0);
    check("nest_pending", pending, 4'b1000);
    int_ret = 1'b1; step(); int_ret = 1'b0;
    check("nest_gap", int_req, 0);
    step();
    check("nest_req3", {int_req, int_vec}, {1'b1, 16'h0f80});
    ack_ret();
    buttons_raw = 4'h0;
    repeat (8) step();

    // Reset wins over ack in REQ
    do_reset();
    buttons_raw = 4'b0100;
    wait_req("rst_ack_req", DB + 8);
    buttons_raw = 4'h0;
    rst = 1'b1; int_ack = 1'b1; step(); int_ack = 1'b0;
    check("rst_ack", {int_req, in_service, pending}, 0);
    rst = 1'b0;
    repeat (8) step();

    // Re-press of an already pending button is absorbed
    do_reset();
    buttons_raw = 4'b0010;
    wait_req("absorb_req", DB + 8);
    buttons_raw = 4'b0000; repeat (8) step();
    buttons_raw = 4'b0010; repeat (10) step();
    ack_ret();
    buttons_raw = 4'b0000;
    seen = 1'b0;
    repeat (12) begin step(); if (int_req || pending != 0) seen = 1'b1; end
    check("absorb_single", seen, 0);

    // Button held through reset yields exactly one event
    rst = 1'b1; buttons_raw = 4'b0100;
    step(); step(); step();
    rst = 1'b0;
    wait_req("held_req", DB + 8);
    check("held_vec", int_vec, 16'h0fa0);
    ack_ret();
    seen = 1'b0;
    repeat (20) begin step(); if (int_req || pending != 0) seen = 1'b1; end
    check("held_once", seen, 0);
    buttons_raw = 4'h0;
    repeat (8) step();

`ifdef INT_MASK_EN
    // Masked button cannot raise an event
    do_reset();
    int_mask = 4'b0010;
    buttons_raw = 4'b0010;
    seen = 1'b0;
    repeat (14) begin step(); if (int_req || pending != 0) seen = 1'b1; end
    check("mask_block", seen, 0);
    buttons_raw = 4'h0;
    repeat (8) step();
    int_mask = 4'b0000;
`endif

    // Randomized traffic against the reference model
    do_reset();
    tgt = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 24) == 0) tgt[b] = ~tgt[b];
        buttons_raw[b] = ($urandom_range(0, 7) == 0) ? ~tgt[b] : tgt[b];
      end
      int_ack = ($urandom_range(0, 3) == 0);
      int_ret = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 699) == 0);
`ifdef INT_MASK_EN
      if ($urandom_range(0, 199) == 0) int_mask = 4'($urandom_range(0, 15));
`endif
      step();
    end
    rst = 1'b0; int_ack = 1'b0; int_ret = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
